// File: rtl/memory_arbiter.sv
// memory_arbiter: N-port requester arbiter in front of one synchronous memory with port-tagged read return.
// Round-robin by default; define MEMORY_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module memory_arbiter #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int NUM_PORTS        = 4,
  parameter int READ_LATENCY     = 1,
  localparam int AW = MEMORY_BUS_WIDTH - 2,
  localparam int BW = MEMORY_BUS_WIDTH / 8
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_PORTS-1:0]                  req_in,
  input  logic [NUM_PORTS*AW-1:0]               addr_in,
  input  logic [NUM_PORTS*MEMORY_BUS_WIDTH-1:0] data_in,
  input  logic [NUM_PORTS*BW-1:0]               wb_in,
  output logic [NUM_PORTS-1:0]                  gnt_out,
  output logic [NUM_PORTS-1:0]                  rvalid_out,
  output logic [MEMORY_BUS_WIDTH-1:0]           rdata_out,
  output logic                                  mem_enable_out,
  output logic [AW-1:0]                         mem_addr_out,
  output logic [MEMORY_BUS_WIDTH-1:0]           mem_data_out,
  output logic [BW-1:0]                         mem_wb_out,
  input  logic [MEMORY_BUS_WIDTH-1:0]           mem_data_in
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic                 any_req_s;
  logic [PW-1:0]        win_idx_s;
  logic [NUM_PORTS-1:0] gnt_s;
  logic [NUM_PORTS-1:0] rvalid_s;
  logic [PW-1:0]        cmd_port_r;
  logic [READ_LATENCY-1:0] tag_valid_r;
  logic [PW-1:0]        tag_port_r [READ_LATENCY];

`ifndef MEMORY_ARB_FIXED_PRIO_EN
  logic [PW-1:0] last_r;

  function automatic logic [PW-1:0] rr_cand(input logic [PW-1:0] last, input int k);
    return PW'((int'(last) + k) % NUM_PORTS);
  endfunction

  // Round-robin pointer: index of the most recently granted port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_r <= PW'(NUM_PORTS - 1);
    end else if (any_req_s) begin
      last_r <= win_idx_s;
    end else begin
      last_r <= last_r;
    end
  end
`endif

  // Winner selection: walk from lowest to highest priority so the last hit wins
  always_comb begin
    any_req_s = |req_in;
    win_idx_s = {PW{1'b0}};
`ifdef MEMORY_ARB_FIXED_PRIO_EN
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      win_idx_s = req_in[i] ? PW'(i) : win_idx_s;
    end
`else
    for (int k = NUM_PORTS; k >= 1; k--) begin
      win_idx_s = req_in[rr_cand(last_r, k)] ? rr_cand(last_r, k) : win_idx_s;
    end
`endif
  end

  // One-hot grant, forced low while reset is held
  always_comb begin
    gnt_s = {NUM_PORTS{1'b0}};
    if (any_req_s && reset) begin
      gnt_s[win_idx_s] = 1'b1;
    end else begin
      gnt_s = {NUM_PORTS{1'b0}};
    end
  end

  assign gnt_out = gnt_s;

  // Command register: capture the granted port's request onto the memory bus
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_enable_out <= 1'b0;
      mem_addr_out   <= {AW{1'b0}};
      mem_data_out   <= {MEMORY_BUS_WIDTH{1'b0}};
      mem_wb_out     <= {BW{1'b0}};
      cmd_port_r     <= {PW{1'b0}};
    end else if (any_req_s) begin
      mem_enable_out <= 1'b1;
      mem_addr_out   <= addr_in[int'(win_idx_s)*AW +: AW];
      mem_data_out   <= data_in[int'(win_idx_s)*MEMORY_BUS_WIDTH +: MEMORY_BUS_WIDTH];
      mem_wb_out     <= wb_in[int'(win_idx_s)*BW +: BW];
      cmd_port_r     <= win_idx_s;
    end else begin
      mem_enable_out <= 1'b0;
    end
  end

  // Read tag pipeline, fed by the issued command so its depth matches the memory latency
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_valid_r <= {READ_LATENCY{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_port_r[i] <= {PW{1'b0}};
      end
    end else begin
      tag_valid_r[0] <= mem_enable_out && (mem_wb_out == {BW{1'b0}});
      tag_port_r[0]  <= cmd_port_r;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid_r[i] <= tag_valid_r[i-1];
        tag_port_r[i]  <= tag_port_r[i-1];
      end
    end
  end

  // Decode the emerging tag into a one-hot read-valid vector
  always_comb begin
    rvalid_s = {NUM_PORTS{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      rvalid_s[i] = tag_valid_r[READ_LATENCY-1] && (tag_port_r[READ_LATENCY-1] == PW'(i));
    end
  end

  // Read return: pulse rvalid and capture memory data; data holds between pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rvalid_out <= {NUM_PORTS{1'b0}};
      rdata_out  <= {MEMORY_BUS_WIDTH{1'b0}};
    end else if (tag_valid_r[READ_LATENCY-1]) begin
      rvalid_out <= rvalid_s;
      rdata_out  <= mem_data_in;
    end else begin
      rvalid_out <= {NUM_PORTS{1'b0}};
      rdata_out  <= rdata_out;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter (4 ports, 32-bit bus, READ_LATENCY=3).
// The fixed-priority expectations follow MEMORY_ARB_FIXED_PRIO_EN when it is defined for the build.
module tb_memory_arbiter;
  localparam int W  = 32;
  localparam int NP = 4;
  localparam int RL = 3;
  localparam int AW = W - 2;
  localparam int BW = W / 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [NP-1:0]     req_in;
  logic [NP*AW-1:0]  addr_in;
  logic [NP*W-1:0]   data_in;
  logic [NP*BW-1:0]  wb_in;
  logic [NP-1:0]     gnt_out;
  logic [NP-1:0]     rvalid_out;
  logic [W-1:0]      rdata_out;
  logic              mem_enable_out;
  logic [AW-1:0]     mem_addr_out;
  logic [W-1:0]      mem_data_out;
  logic [BW-1:0]     mem_wb_out;
  logic [W-1:0]      mem_data_in;

  int total = 0;
  int bad   = 0;

  memory_arbiter #(.MEMORY_BUS_WIDTH(W), .NUM_PORTS(NP), .READ_LATENCY(RL)) dut (
    .clock(clock), .reset(reset), .req_in(req_in), .addr_in(addr_in),
    .data_in(data_in), .wb_in(wb_in), .gnt_out(gnt_out), .rvalid_out(rvalid_out),
    .rdata_out(rdata_out), .mem_enable_out(mem_enable_out), .mem_addr_out(mem_addr_out),
    .mem_data_out(mem_data_out), .mem_wb_out(mem_wb_out), .mem_data_in(mem_data_in)
  );

  always #5 clock = ~clock;

  // Behavioural synchronous memory with RL cycles from command to data
  logic [W-1:0] mem [0:63];
  logic [W-1:0] rd_pipe [0:RL-1];
  assign mem_data_in = rd_pipe[RL-1];

  always @(posedge clock) begin
    if (mem_enable_out) begin
      for (int b = 0; b < BW; b++) begin
        if (mem_wb_out[b]) mem[mem_addr_out[5:0]][8*b +: 8] <= mem_data_out[8*b +: 8];
      end
      rd_pipe[0] <= mem[mem_addr_out[5:0]];
    end
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [W-1:0] d,
                          input logic [BW-1:0] w);
    addr_in[p*AW +: AW] = a;
    data_in[p*W +: W]   = d;
    wb_in[p*BW +: BW]   = w;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [NP-1:0] e;
    reset   = 1'b0;
    req_in  = '0;
    addr_in = '0;
    data_in = '0;
    wb_in   = '0;
    for (int p = 0; p < NP; p++) set_port(p, AW'(10 + p), 32'h0000_00A0 + W'(p), 4'hF);
    req_in = 4'b1111;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_gnt",    64'(gnt_out),        64'd0);
    check_eq("rst_en",     64'(mem_enable_out), 64'd0);
    check_eq("rst_addr",   64'(mem_addr_out),   64'd0);
    check_eq("rst_data",   64'(mem_data_out),   64'd0);
    check_eq("rst_wb",     64'(mem_wb_out),     64'd0);
    check_eq("rst_rvalid", 64'(rvalid_out),     64'd0);
    check_eq("rst_rdata",  64'(rdata_out),      64'd0);

    // Round robin with all ports writing
    step();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      e = 4'b0001 << (k % 4);
      check_eq("rr_gnt", 64'(gnt_out), 64'(e));
      check_eq("rr_en",  64'(mem_enable_out), 64'(k >= 1));
      if (k >= 1) check_eq("rr_addr", 64'(mem_addr_out), 64'(10 + ((k - 1) % 4)));
      step();
    end
    req_in = 4'b0000;
    @(negedge clock);
    check_eq("idle_gnt",  64'(gnt_out),        64'd0);
    check_eq("tail_en",   64'(mem_enable_out), 64'd1);
    check_eq("tail_addr", 64'(mem_addr_out),   64'd13);
    step();
    @(negedge clock);
    check_eq("idle_en", 64'(mem_enable_out), 64'd0);

    // Port 2 writes, port 1 reads the same word back
    step();
    set_port(2, AW'(5), 32'hDEADBEEF, 4'hF);
    req_in = 4'b0100;
    @(negedge clock);
    check_eq("wr_gnt", 64'(gnt_out), 64'b0100);
    step();
    set_port(1, AW'(5), 32'h0, 4'h0);
    req_in = 4'b0010;
    @(negedge clock);
    check_eq("rd_gnt",  64'(gnt_out),        64'b0010);
    check_eq("wr_en",   64'(mem_enable_out), 64'd1);
    check_eq("wr_addr", 64'(mem_addr_out),   64'd5);
    check_eq("wr_data", 64'(mem_data_out),   64'hDEADBEEF);
    check_eq("wr_wb",   64'(mem_wb_out),     64'hF);
    for (int c = 1; c <= RL + 3; c++) begin
      step();
      req_in = 4'b0000;
      @(negedge clock);
      if (c == 1) begin
        check_eq("rd_addr", 64'(mem_addr_out), 64'd5);
        check_eq("rd_wb",   64'(mem_wb_out),   64'd0);
      end
      check_eq("rd_rvalid", 64'(rvalid_out), (c == RL + 2) ? 64'b0010 : 64'd0);
      if (c == RL + 2) check_eq("rd_rdata", 64'(rdata_out), 64'hDEADBEEF);
    end

    // Partial-byte write passes wb through and returns nothing
    step();
    set_port(0, AW'(7), 32'h11223344, 4'b0110);
    req_in = 4'b0001;
    @(negedge clock);
    check_eq("pw_gnt", 64'(gnt_out), 64'b0001);
    for (int c = 1; c <= RL + 3; c++) begin
      step();
      req_in = 4'b0000;
      @(negedge clock);
      if (c == 1) begin
        check_eq("pw_wb",   64'(mem_wb_out),   64'b0110);
        check_eq("pw_data", 64'(mem_data_out), 64'h11223344);
        check_eq("pw_addr", 64'(mem_addr_out), 64'd7);
      end
      check_eq("pw_rvalid", 64'(rvalid_out), 64'd0);
    end

    // Back-to-back reads from ports 3 and 0 complete in issue order
    step();
    set_port(0, AW'(10), 32'h0, 4'h0);
    set_port(3, AW'(13), 32'h0, 4'h0);
    req_in = 4'b1001;
    @(negedge clock);
    check_eq("ord_gnt0", 64'(gnt_out), 64'b1000);
    step();
    req_in = 4'b0001;
    @(negedge clock);
    check_eq("ord_gnt1", 64'(gnt_out), 64'b0001);
    for (int c = 2; c <= RL + 4; c++) begin
      step();
      req_in = 4'b0000;
      @(negedge clock);
      if (c == RL + 2) begin
        check_eq("ord_rv3", 64'(rvalid_out), 64'b1000);
        check_eq("ord_rd3", 64'(rdata_out),  64'hA3);
      end else if (c == RL + 3) begin
        check_eq("ord_rv0", 64'(rvalid_out), 64'b0001);
        check_eq("ord_rd0", 64'(rdata_out),  64'hA0);
      end else begin
        check_eq("ord_rvz", 64'(rvalid_out), 64'd0);
      end
    end

    // Reset pulse right after a port 3 read grant discards the read
    step();
    set_port(3, AW'(5), 32'h0, 4'h0);
    req_in = 4'b1000;
    @(negedge clock);
    check_eq("mr_gnt", 64'(gnt_out), 64'b1000);
    step();
    req_in = 4'b0000;
    reset  = 1'b0;
    @(negedge clock);
    check_eq("mr_en", 64'(mem_enable_out), 64'd0);
    step();
    reset = 1'b1;
    @(negedge clock);
    check_eq("mr_rdata", 64'(rdata_out), 64'd0);
    for (int c = 1; c <= 10; c++) begin
      check_eq("mr_rvalid", 64'(rvalid_out), 64'd0);
      step();
      @(negedge clock);
    end

    // Ports 1 and 3 requesting together
    step();
    set_port(1, AW'(20), 32'h0000_0011, 4'hF);
    set_port(3, AW'(21), 32'h0000_0033, 4'hF);
    req_in = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
`ifdef MEMORY_ARB_FIXED_PRIO_EN
      e = 4'b0010;
`else
      e = (k % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
      check_eq("pair_gnt", 64'(gnt_out), 64'(e));
      step();
    end
    req_in = 4'b0000;
    repeat (2) @(posedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
